systolic_skew_feeder: RTL and testbench

- Upstream feeder for the PE row: buffers whole input rows of M operands and drives them onto the per-column B inputs with diagonal skew, so column k gets element k exactly k cycles after column 0.
- Provides a ready/valid input port, an output stall (out_ready) shared with the array, and a tile-done pulse once the last row has fully exited.

---
 rtl/systolic_skew_feeder.sv | 131 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Row FIFO feeding a PE row with diagonal skew: lane k is delayed k cycles behind lane 0.
// A shared out_ready stall freezes every skew stage; out_done flags the last row leaving lane M-1.
module systolic_skew_feeder #(
  parameter int unsigned N     = 32,
  parameter int unsigned M     = 5,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M*N-1:0] in_data,
  input  logic           in_last,
  input  logic           out_ready,
  output logic [M*N-1:0] out_data,
  output logic [M-1:0]   out_valid,
  output logic           out_done,
  output logic           busy,
  output logic [AW:0]    count
);

  localparam int unsigned EW = M * N + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] head;
  logic [M*N-1:0] ld_data;
  logic          ld_valid, ld_last;
  logic [M-1:0]  lane_any_v;
  logic          done_in;
  logic          out_done_q, out_done_d;

  // No bypass when full: acceptance depends only on the registered occupancy.
  assign in_ready = clr_n & (count_q < (AW+1)'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = out_ready & (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  // Stage-0 load: FIFO head on a pop, otherwise a bubble.
  assign ld_valid = pop;
  assign ld_last  = pop & head[EW-1];
  assign ld_data  = pop ? head[M*N-1:0] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; only occupancy decides what is read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  for (genvar k = 0; k < M; k++) begin : g_lane
    logic [N-1:0] dat_q [k+1];
    logic [k:0]   vld_q;

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        for (int j = 0; j <= k; j++) dat_q[j] <= '0;
        vld_q <= '0;
      end else if (out_ready) begin
        dat_q[0] <= ld_data[k*N +: N];
        vld_q[0] <= ld_valid;
        for (int j = 1; j <= k; j++) begin
          dat_q[j] <= dat_q[j-1];
          vld_q[j] <= vld_q[j-1];
        end
      end
    end

    assign out_data[k*N +: N] = dat_q[k];
    assign out_valid[k]       = vld_q[k];
    assign lane_any_v[k]      = |vld_q;
  end

  // The last tag only matters on lane M-1, one stage ahead of its output.
  if (M > 1) begin : g_last_chain
    logic [M-2:0] lst_q;

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        lst_q <= '0;
      end else if (out_ready) begin
        lst_q[0] <= ld_last;
        for (int j = 1; j <= int'(M) - 2; j++) lst_q[j] <= lst_q[j-1];
      end
    end

    assign done_in = lst_q[M-2];
  end else begin : g_last_direct
    assign done_in = ld_last;
  end

  // Pulse only on the fire that moves the tagged element into the final stage.
  assign out_done_d = out_ready & done_in;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) out_done_q <= 1'b0;
    else        out_done_q <= out_done_d;
  end

  assign out_done = out_done_q;
  assign count    = count_q;
  assign busy     = (count_q != '0) | (|lane_any_v);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: skew timing, back-pressure, stalls, bubbles, async reset.
module tb_systolic_skew_feeder;

  localparam int unsigned N     = 32;
  localparam int unsigned M     = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic           clk = 1'b0;
  logic           clr_n;
  logic           in_valid;
  logic           in_ready;
  logic [M*N-1:0] in_data;
  logic           in_last;
  logic           out_ready;
  logic [M*N-1:0] out_data;
  logic [M-1:0]   out_valid;
  logic           out_done;
  logic           busy;
  logic [AW:0]    count;

  int errors = 0;
  int checks = 0;

  systolic_skew_feeder #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_done(out_done),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row whose lane k holds b+k.
  function automatic logic [M*N-1:0] mk(input int b);
    logic [M*N-1:0] v;
    for (int k = 0; k < int'(M); k++) v[k*N +: N] = N'(b + k);
    return v;
  endfunction

  function automatic logic [M*N-1:0] lanes(input int a0, input int a1, input int a2,
                                           input int a3, input int a4);
    return {N'(a4), N'(a3), N'(a2), N'(a1), N'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [M*N-1:0] d, input logic [M-1:0] v,
                         input logic dn);
    chk({tag, ".data"}, 256'(out_data), 256'(d));
    chk({tag, ".valid"}, 256'(out_valid), 256'(v));
    chk({tag, ".done"}, 256'(out_done), 256'(dn));
  endtask

  initial begin
    logic [M*N-1:0] ed;
    logic [M-1:0]   ev;
    int r;

    clr_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #22;
    chk("rst.in_ready", 256'(in_ready), 256'(0));
    chk("rst.count", 256'(count), 256'(0));
    chk("rst.busy", 256'(busy), 256'(0));
    chk_out("rst", '0, '0, 1'b0);
    @(posedge clk); #1 clr_n = 1'b1;
    tick();
    chk("idle.in_ready", 256'(in_ready), 256'(1));

    // Single row, walking one-hot valid
    in_valid = 1'b1; in_data = mk(1); in_last = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1.count", 256'(count), 256'(1));
    chk("t1.busy0", 256'(busy), 256'(1));
    chk_out("t1.e0", '0, 5'b00000, 1'b0);
    tick(); chk_out("t1.e1", lanes(1, 0, 0, 0, 0), 5'b00001, 1'b0);
    chk("t1.count_pop", 256'(count), 256'(0));
    tick(); chk_out("t1.e2", lanes(0, 2, 0, 0, 0), 5'b00010, 1'b0);
    tick(); chk_out("t1.e3", lanes(0, 0, 3, 0, 0), 5'b00100, 1'b0);
    tick(); chk_out("t1.e4", lanes(0, 0, 0, 4, 0), 5'b01000, 1'b0);
    tick(); chk_out("t1.e5", lanes(0, 0, 0, 0, 5), 5'b10000, 1'b1);
    chk("t1.busy5", 256'(busy), 256'(1));
    tick(); chk_out("t1.e6", '0, 5'b00000, 1'b0);
    chk("t1.busy6", 256'(busy), 256'(0));

    // Back-to-back rows: lane k of row r = 10r+k, lane k shows row r after edge r+1+k
    for (int t = 0; t <= 9; t++) begin
      in_valid = (t < 4);
      in_data  = mk(10 * t);
      in_last  = (t == 3);
      tick();
      ed = '0; ev = '0;
      for (int k = 0; k < int'(M); k++) begin
        r = t - 1 - k;
        if (r >= 0 && r < 4) begin
          ed[k*N +: N] = N'(10 * r + k);
          ev[k] = 1'b1;
        end
      end
      chk_out($sformatf("b2b.t%0d", t), ed, ev, t == 8);
      chk($sformatf("b2b.busy%0d", t), 256'(busy), 256'(t < 9));
      chk($sformatf("b2b.rdy%0d", t), 256'(in_ready), 256'(1));
    end
    in_valid = 1'b0; in_last = 1'b0;

    // Bubble insertion: rows at t=0 and t=3 leave two empty diagonals
    for (int t = 0; t <= 9; t++) begin
      in_valid = (t == 0) || (t == 3);
      in_data  = (t == 0) ? mk(50) : mk(60);
      in_last  = (t == 3);
      tick();
      ed = '0; ev = '0;
      for (int k = 0; k < int'(M); k++) begin
        if (t == 1 + k) begin ed[k*N +: N] = N'(50 + k); ev[k] = 1'b1; end
        if (t == 4 + k) begin ed[k*N +: N] = N'(60 + k); ev[k] = 1'b1; end
      end
      chk_out($sformatf("bub.t%0d", t), ed, ev, t == 8);
      chk($sformatf("bub.busy%0d", t), 256'(busy), 256'(t < 9));
    end
    in_valid = 1'b0; in_last = 1'b0;

    // Fill FIFO under stall
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = mk(100 + 10 * i); in_last = (i == 3);
      tick();
    end
    chk("full.count", 256'(count), 256'(4));
    chk("full.in_ready", 256'(in_ready), 256'(0));
    chk("full.busy", 256'(busy), 256'(1));
    chk("full.valid", 256'(out_valid), 256'(0));
    in_data = mk(200); in_last = 1'b0;
    tick();
    chk("full.refused", 256'(count), 256'(4));
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("full.pop_refused", 256'(count), 256'(3));
    chk("full.rdy_after", 256'(in_ready), 256'(1));
    chk_out("full.g0", lanes(100, 0, 0, 0, 0), 5'b00001, 1'b0);
    tick(); chk_out("full.g1", lanes(110, 101, 0, 0, 0), 5'b00011, 1'b0);
    tick(); chk_out("full.g2", lanes(120, 111, 102, 0, 0), 5'b00111, 1'b0);
    chk("full.count_g2", 256'(count), 256'(1));

    // Stall mid-stream for three cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("stall.%0d", i), lanes(120, 111, 102, 0, 0), 5'b00111, 1'b0);
      chk($sformatf("stall.count%0d", i), 256'(count), 256'(1));
    end
    out_ready = 1'b1;
    tick(); chk_out("res.g3", lanes(130, 121, 112, 103, 0), 5'b01111, 1'b0);
    chk("res.count", 256'(count), 256'(0));
    tick(); chk_out("res.g4", lanes(0, 131, 122, 113, 104), 5'b11110, 1'b0);
    tick(); chk_out("res.g5", lanes(0, 0, 132, 123, 114), 5'b11100, 1'b0);
    tick(); chk_out("res.g6", lanes(0, 0, 0, 133, 124), 5'b11000, 1'b0);
    tick(); chk_out("res.g7", lanes(0, 0, 0, 0, 134), 5'b10000, 1'b1);
    chk("res.busy7", 256'(busy), 256'(1));
    tick(); chk_out("res.g8", '0, 5'b00000, 1'b0);
    chk("res.busy8", 256'(busy), 256'(0));

    // Async reset with rows in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = mk(70 + 10 * i); in_last = (i == 2);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk_out("ar.pre", lanes(80, 71, 0, 0, 0), 5'b00011, 1'b0);
    #3 clr_n = 1'b0;
    #1;
    chk_out("ar.clr", '0, 5'b00000, 1'b0);
    chk("ar.count", 256'(count), 256'(0));
    chk("ar.busy", 256'(busy), 256'(0));
    chk("ar.in_ready", 256'(in_ready), 256'(0));
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("ar.quiet%0d", i), '0, 5'b00000, 1'b0);
    end
    in_valid = 1'b1; in_data = mk(7); in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("ar.count_push", 256'(count), 256'(1));
    tick(); chk_out("ar.resume", lanes(7, 0, 0, 0, 0), 5'b00001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
